// File: rtl/ntt_iter_engine.sv
// In-place radix-2 DIT NTT/INTT over Z_q: bit-reversed load, one butterfly per clock,
// optional N^-1 scaling, natural-order streaming drain with valid/ready on both sides.
module ntt_iter_engine #(
  parameter int LOGN       = 9,
  parameter int DATA_WIDTH = 16,
  parameter int MODULUS    = 7681,
  parameter int ROOT       = 7146,
  parameter int ROOT_INV   = 7480,
  parameter int N_INV      = 7666
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int N  = 1 << LOGN;
  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW-1:0]         Q_P      = PW'(MODULUS);
  localparam logic [DATA_WIDTH:0]   Q_S      = (DATA_WIDTH + 1)'(MODULUS);
  localparam logic [DATA_WIDTH-1:0] ROOT_F   = DATA_WIDTH'(ROOT);
  localparam logic [DATA_WIDTH-1:0] ROOTI_F  = DATA_WIDTH'(ROOT_INV);
  localparam logic [DATA_WIDTH-1:0] NINV_F   = DATA_WIDTH'(N_INV);
  localparam logic [DATA_WIDTH-1:0] ONE_F    = DATA_WIDTH'(1);
  localparam logic [LOGN-1:0]       LAST_IDX = LOGN'(N - 1);
  localparam logic [LOGN-1:0]       LAST_PREP = LOGN'(LOGN - 1);
  localparam logic [SW-1:0]         LAST_S   = SW'(LOGN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PREP, COMP, SCALE, DRAIN} state_t;

  function automatic logic [DATA_WIDTH-1:0] mod_mul(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [PW-1:0] prod;
    prod = PW'(a) * PW'(b);
    return DATA_WIDTH'(prod % Q_P);
  endfunction

  state_t                state_reg, state_next;
  logic                  mode_reg, mode_next;
  logic [LOGN-1:0]       idx_reg, idx_next;
  logic [SW-1:0]         s_reg, s_next;
  logic [LOGN-1:0]       j_reg, j_next;
  logic [LOGN-1:0]       b_reg, b_next;
  logic [DATA_WIDTH-1:0] w_reg, w_next;
  logic                  done_reg, done_next;

  logic [DATA_WIDTH-1:0] mem [N];
  logic [DATA_WIDTH-1:0] stage_root [LOGN];

  // Load address is the bit-reversed beat index so the DIT loop yields natural-order output.
  logic [LOGN-1:0] load_addr;
  for (genvar gi = 0; gi < LOGN; gi++) begin : g_bitrev
    assign load_addr[gi] = idx_reg[LOGN-1-gi];
  end

  logic [DATA_WIDTH-1:0] in_mod;
  assign in_mod = DATA_WIDTH'(PW'(in_data) % Q_P);

  logic [LOGN-1:0]       half, bf_i, bf_p;
  logic [LOGN:0]         next_b_wide;
  logic                  b_wrap;
  logic [DATA_WIDTH-1:0] op_a, op_b, tw, bf_sum, bf_diff, cur_root, scaled;
  logic [DATA_WIDTH:0]   sum_w, diff_w;

  assign half        = LOGN'(1) << s_reg;
  assign bf_i        = b_reg + j_reg;
  assign bf_p        = bf_i + half;
  assign next_b_wide = {1'b0, b_reg} + {half, 1'b0};
  assign b_wrap      = (next_b_wide == (LOGN + 1)'(N));
  assign op_a        = mem[bf_i];
  assign op_b        = mem[bf_p];
  assign cur_root    = stage_root[s_reg];
  assign tw          = mod_mul(w_reg, op_b);
  assign sum_w       = {1'b0, op_a} + {1'b0, tw};
  assign diff_w      = {1'b0, op_a} + Q_S - {1'b0, tw};
  assign bf_sum      = (sum_w >= Q_S) ? DATA_WIDTH'(sum_w - Q_S) : DATA_WIDTH'(sum_w);
  assign bf_diff     = (op_a >= tw) ? (op_a - tw) : DATA_WIDTH'(diff_w);
  assign scaled      = mod_mul(mem[idx_reg], NINV_F);

  // Root table fills top-down: the first PREP cycle seeds the N-th root, later cycles square.
  logic [LOGN-1:0]       root_dst, root_src;
  logic [DATA_WIDTH-1:0] root_sq, root_wr;
  assign root_dst = LAST_PREP - idx_reg;
  assign root_src = (idx_reg == '0) ? root_dst : root_dst + LOGN'(1);
  assign root_sq  = mod_mul(stage_root[root_src], stage_root[root_src]);
  assign root_wr  = (idx_reg == '0) ? (mode_reg ? ROOTI_F : ROOT_F) : root_sq;

  always_ff @(posedge clk) begin
    if (state_reg == PREP) stage_root[root_dst] <= root_wr;
  end

  always_ff @(posedge clk) begin
    if (state_reg == LOAD && in_valid) mem[load_addr] <= in_mod;
    if (state_reg == COMP) begin
      mem[bf_i] <= bf_sum;
      mem[bf_p] <= bf_diff;
    end
    if (state_reg == SCALE) mem[idx_reg] <= scaled;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      mode_reg  <= 1'b0;
      idx_reg   <= '0;
      s_reg     <= '0;
      j_reg     <= '0;
      b_reg     <= '0;
      w_reg     <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      idx_reg   <= idx_next;
      s_reg     <= s_next;
      j_reg     <= j_next;
      b_reg     <= b_next;
      w_reg     <= w_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    idx_next   = idx_reg;
    s_next     = s_reg;
    j_next     = j_reg;
    b_next     = b_reg;
    w_next     = w_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next  = mode;
          idx_next   = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          idx_next = idx_reg + LOGN'(1);
          if (idx_reg == LAST_IDX) state_next = PREP;
        end
      end
      PREP: begin
        idx_next = idx_reg + LOGN'(1);
        if (idx_reg == LAST_PREP) begin
          idx_next   = '0;
          s_next     = '0;
          j_next     = '0;
          b_next     = '0;
          w_next     = ONE_F;
          state_next = COMP;
        end
      end
      COMP: begin
        b_next = next_b_wide[LOGN-1:0];
        if (b_wrap) begin
          b_next = '0;
          j_next = j_reg + LOGN'(1);
          w_next = mod_mul(w_reg, cur_root);
          if (j_reg == half - LOGN'(1)) begin
            j_next = '0;
            w_next = ONE_F;
            s_next = s_reg + SW'(1);
            if (s_reg == LAST_S) begin
              s_next     = '0;
              state_next = mode_reg ? SCALE : DRAIN;
            end
          end
        end
      end
      SCALE: begin
        idx_next = idx_reg + LOGN'(1);
        if (idx_reg == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          idx_next = idx_reg + LOGN'(1);
          if (idx_reg == LAST_IDX) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == LOAD);
  assign out_valid = (state_reg == DRAIN);
  assign out_data  = (state_reg == DRAIN) ? mem[idx_reg] : '0;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

endmodule
